viterbi_frame_ctrl: RTL
=======================

Name: viterbi_frame_ctrl

Overview:
- Frame sequencer for the K=3 (4-state) Viterbi decoder.
- Accepts received symbol pairs over a valid/ready handshake and paces the BMC/ACS datapath one symbol per accepted pair.
- Writes ACS decisions into the survivor memory, then runs traceback over the stored frame.
- Delivers the decoded FRAME_LEN-bit word over a second valid/ready handshake.
- Sits between the demodulator front end and the BMC/ACS array plus survivor RAM.

Parameters:
- FRAME_LEN, 16: symbols per frame (≥2). Derived ADDR_W = $clog2(FRAME_LEN).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  rx_pair valid
- in_ready  out  1  controller accepts rx_pair
- rx_pair  in  2  received code pair
- bmc_rx_pair  out  2  rx_pair forwarded to BMC array (combinational pass-through)
- pm_clr  out  1  ACS path-metric init: state 0 = 0, others = max
- acs_en  out  1  ACS registers new metrics/decisions this cycle
- best_state  in  2  ACS minimum-metric state after the current update
- sm_wr_en  out  1  survivor RAM write strobe; data comes from ACS decisions
- sm_wr_addr  out  ADDR_W  survivor write address
- sm_rd_en  out  1  survivor RAM read strobe
- sm_rd_addr  out  ADDR_W  survivor read address
- sm_rd_data  in  4  decision word, one bit per state, valid 1 cycle after sm_rd_en
- out_valid  out  1  decoded frame available
- out_ready  in  1  consumer accepts frame
- out_bits  out  FRAME_LEN  decoded bits, bit i = symbol i (i=0 first received)

Behaviour:
- Reset and clocking
  - One clock; reset is asynchronous, active-low.
  - During reset: FSM=IDLE; all outputs 0; sym_cnt, tb_state and out_bits cleared.
  - Reset mid-frame aborts the frame. Partial data is discarded. The next frame restarts at address 0.
- FSM states: IDLE, ACS, TB, OUT.
- IDLE
  - Lasts exactly 1 cycle; pm_clr=1, in_ready=0; next state ACS.
- ACS
  - in_ready=1.
  - On in_valid&in_ready: acs_en=1, sm_wr_en=1, sm_wr_addr=sym_cnt, sym_cnt++.
  - No accept means no strobes and sym_cnt holds.
  - On accepting symbol FRAME_LEN-1: latch best_state into tb_state, clear sym_cnt, go to TB.
  - best_state is sampled in that same cycle.
- TB
  - Read issue: cycle k (k=0..FRAME_LEN-1) drives sm_rd_en=1, sm_rd_addr=FRAME_LEN-1-k.
  - Data processing: cycle k+1 consumes sm_rd_data for address a=FRAME_LEN-1-k.
  - Per data word: out_bits[a] <= tb_state[1]; tb_state <= {tb_state[0], sm_rd_data[tb_state]}.
  - Read issue and data processing overlap. TB lasts FRAME_LEN+1 cycles.
  - After processing address 0, go to OUT. in_ready=0 throughout TB.
- OUT
  - out_valid=1; out_bits held stable; in_ready=0.
  - On out_ready, go to IDLE; out_valid drops the next cycle.
  - out_ready is ignored in all other states.
- Output decoding
  - All strobes are decoded from the registered state and counters, plus in_valid for acs_en/sm_wr_en.
  - Only one of sm_wr_en and sm_rd_en is ever high.
- Throughput: one symbol per cycle in ACS. Frame period = 1 + FRAME_LEN + (FRAME_LEN+1) + ≥1 cycles.
- Counter rules
  - sym_cnt and the read address are ADDR_W wide and never wrap past FRAME_LEN-1.
  - For non-power-of-two FRAME_LEN, addresses ≥ FRAME_LEN are never issued.

Test Plan:
- Reset: hold rst_n=0 with random inputs → all outputs 0. Release → 1 cycle with pm_clr=1, then in_ready=1.
- Continuous frame (FRAME_LEN=16, in_valid=1): acs_en and sm_wr_en high for 16 cycles, addresses 0..15. in_ready low the cycle after the 16th accept. TB reads addresses 15..0 on 16 consecutive cycles.
- Traceback, all-ones: memory all 4'b1111, best_state=2'b11 → out_bits=16'hFFFF. Traceback, single one: memory all 4'b0000, best_state=2'b10 → out_bits=16'h8000.
- Input bubbles: in_valid toggles 1,0,0,1,… → acs_en only on accepted cycles, sm_wr_addr contiguous 0..15, no skipped or repeated addresses.
- Output backpressure: out_ready low for 5 cycles in OUT → out_valid=1 and out_bits stable, in_ready=0. Raise out_ready → IDLE with pm_clr pulse, then new frame accepted.
- Reset mid-TB (after reading address 9): outputs clear immediately. The next frame writes from address 0 and decodes correctly.

Source files
------------

// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer for a K=3 Viterbi decoder: paces BMC/ACS per accepted symbol pair,
// fills the survivor RAM, runs traceback over the frame and hands out the decoded word.
module viterbi_frame_ctrl #(
    parameter int unsigned FRAME_LEN = 16,
    localparam int unsigned ADDR_W = $clog2(FRAME_LEN)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           rx_pair,
    output logic [1:0]           bmc_rx_pair,
    output logic                 pm_clr,
    output logic                 acs_en,
    input  logic [1:0]           best_state,
    output logic                 sm_wr_en,
    output logic [ADDR_W-1:0]    sm_wr_addr,
    output logic                 sm_rd_en,
    output logic [ADDR_W-1:0]    sm_rd_addr,
    input  logic [3:0]           sm_rd_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [FRAME_LEN-1:0] out_bits
);

    // Traceback counter spans FRAME_LEN+1 cycles (read issue plus one trailing data cycle).
    localparam int unsigned KW = $clog2(FRAME_LEN + 1);
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(FRAME_LEN - 1);
    localparam logic [KW-1:0]     TbLast   = KW'(FRAME_LEN);

    typedef enum logic [1:0] {StIdle, StAcs, StTb, StOut} state_e;

    state_e                state_q, state_d;
    logic [ADDR_W-1:0]     sym_cnt_q, sym_cnt_d;
    logic [KW-1:0]         tb_cnt_q, tb_cnt_d;
    logic [1:0]            tb_state_q, tb_state_d;
    logic [FRAME_LEN-1:0]  out_bits_q, out_bits_d;
    logic                  accept;
    logic [ADDR_W-1:0]     proc_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            sym_cnt_q  <= '0;
            tb_cnt_q   <= '0;
            tb_state_q <= '0;
            out_bits_q <= '0;
        end else begin
            state_q    <= state_d;
            sym_cnt_q  <= sym_cnt_d;
            tb_cnt_q   <= tb_cnt_d;
            tb_state_q <= tb_state_d;
            out_bits_q <= out_bits_d;
        end
    end

    assign accept    = (state_q == StAcs) && in_valid;
    // Data returned this cycle belongs to the address issued one cycle earlier.
    assign proc_addr = ADDR_W'(TbLast - tb_cnt_q);

    always_comb begin
        state_d    = state_q;
        sym_cnt_d  = sym_cnt_q;
        tb_cnt_d   = tb_cnt_q;
        tb_state_d = tb_state_q;
        out_bits_d = out_bits_q;
        unique case (state_q)
            StIdle: begin
                sym_cnt_d = '0;
                tb_cnt_d  = '0;
                state_d   = StAcs;
            end
            StAcs: begin
                if (accept) begin
                    if (sym_cnt_q == LastAddr) begin
                        sym_cnt_d  = '0;
                        tb_cnt_d   = '0;
                        tb_state_d = best_state;
                        state_d    = StTb;
                    end else begin
                        sym_cnt_d = sym_cnt_q + ADDR_W'(1);
                    end
                end
            end
            StTb: begin
                tb_cnt_d = tb_cnt_q + KW'(1);
                if (tb_cnt_q != '0) begin
                    out_bits_d[proc_addr] = tb_state_q[1];
                    tb_state_d = {tb_state_q[0], sm_rd_data[tb_state_q]};
                end
                if (tb_cnt_q == TbLast) begin
                    tb_cnt_d = '0;
                    state_d  = StOut;
                end
            end
            StOut: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        // pm_clr is qualified by rst_n so every output reads 0 while reset is held.
        pm_clr      = (state_q == StIdle) && rst_n;
        in_ready    = (state_q == StAcs);
        bmc_rx_pair = (state_q == StAcs) ? rx_pair : 2'b00;
        acs_en      = accept;
        sm_wr_en    = accept;
        sm_wr_addr  = accept ? sym_cnt_q : '0;
        sm_rd_en    = (state_q == StTb) && (tb_cnt_q != TbLast);
        sm_rd_addr  = sm_rd_en ? ADDR_W'(TbLast - KW'(1) - tb_cnt_q) : '0;
        out_valid   = (state_q == StOut);
        out_bits    = out_bits_q;
    end

endmodule
